div_fu: RTL and testbench

- Iterative integer-divide functional unit for AArch64 UDIV/SDIV, in 64-bit (X) and 32-bit (W) forms.
- Implements the FU side of the functional-unit interface. The issue/controller logic drives the instruction; this block returns the result, destination PRN and instruction ID.
- Radix-2 restoring divider, one quotient bit per clock. Adds a `busy` output so the controller knows when it may issue.

---
 rtl/div_fu_if.sv | 31 +++
 rtl/div_fu.sv | 144 ++++++++++++++
 tb/tb_div_fu.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/div_fu_if.sv
// Functional-unit interface: controller issues an instruction with operands,
// the FU returns per-slot results with the instruction ID and a busy indication.
interface div_fu_if #(
  parameter int INST_ID_BITS = 8,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
);
  logic [INST_ID_BITS-1:0]               inst_id;
  logic [31:0]                           inst;
  logic [MAX_OPERANDS-1:0][63:0]         op;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
  logic [63:0]                           pc;
  logic                                  inst_valid;

  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn_o;
  logic [MAX_OPERANDS-1:0][63:0]         out_data;
  logic [MAX_OPERANDS-1:0]               out_slot_valid;
  logic [INST_ID_BITS-1:0]               out_inst_id;
  logic                                  out_valid;
  logic                                  busy;

  modport master (
    output inst_id, inst, op, out_prn, pc, inst_valid,
    input  out_prn_o, out_data, out_slot_valid, out_inst_id, out_valid, busy
  );

  modport slave (
    input  inst_id, inst, op, out_prn, pc, inst_valid,
    output out_prn_o, out_data, out_slot_valid, out_inst_id, out_valid, busy
  );
endinterface

// File: rtl/div_fu.sv
// Iterative radix-2 restoring divider for AArch64 UDIV/SDIV (X and W forms),
// one quotient bit per clock, completion reported through the FU interface.
module div_fu #(
  parameter int INST_ID_BITS = 8,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
) (
  input logic     clk,
  input logic     rst,
  div_fu_if.slave fu
);

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [INST_ID_BITS-1:0] id_p0;
  logic [31:0]             inst_p0;
  logic [63:0]             rn_p0, rm_p0;
  logic [PRN_BITS-1:0]     prn_p0;

  logic [63:0] rem_p1, quo_p1, dvs_p1;
  logic [6:0]  cnt_p1;
  logic        neg_p1;

  logic [INST_ID_BITS-1:0] id_q;
  logic [PRN_BITS-1:0]     prn0_q;
  logic [63:0]             data0_q;
  logic                    slot0_q;

  logic        accept, sf, sgn, xzr, recog, dvz, neg, qbit;
  logic [63:0] rn_ext, rm_ext, rn_mag, rm_mag, dividend, res_val;
  logic [64:0] rem_sh, trial;

  logic unused_fu;
  assign unused_fu = ^{fu.pc, fu.op, fu.out_prn};

  function automatic logic [63:0] mag(input logic signed [63:0] v, input logic sgn_en);
    return (sgn_en && v[63]) ? 64'(-v) : 64'(v);
  endfunction

  function automatic logic [63:0] apply_sign(input logic [63:0] q, input logic neg_en,
                                             input logic x_form);
    logic signed [63:0] qs;
    logic signed [31:0] qw;
    qs = neg_en ? -$signed(q) : $signed(q);
    qw = neg_en ? -$signed(q[31:0]) : $signed(q[31:0]);
    return x_form ? qs : {32'b0, qw};
  endfunction

  assign accept = fu.inst_valid && (state == IDLE || state == DONE);

  // Decode; bit 10 is the signed select, so it is left out of the match.
  assign sf    = inst_p0[31];
  assign sgn   = inst_p0[10];
  assign xzr   = (inst_p0[4:0] == 5'd31);
  assign recog = ((inst_p0 & 32'h7FE0_F800) == 32'h1AC0_0800);

  // W form works on the low word, sign-extended only for SDIV before taking magnitudes.
  assign rn_ext   = sf ? rn_p0 : {{32{rn_p0[31] & sgn}}, rn_p0[31:0]};
  assign rm_ext   = sf ? rm_p0 : {{32{rm_p0[31] & sgn}}, rm_p0[31:0]};
  assign rn_mag   = mag(rn_ext, sgn);
  assign rm_mag   = mag(rm_ext, sgn);
  assign dvz      = (rm_mag == 64'd0);
  assign neg      = sgn & (rn_ext[63] ^ rm_ext[63]);
  assign dividend = sf ? rn_mag : {rn_mag[31:0], 32'b0};

  assign rem_sh = {rem_p1, quo_p1[63]};
  assign trial  = rem_sh - {1'b0, dvs_p1};
  assign qbit   = ~trial[64];

  assign res_val = (state == FIX) ? apply_sign(quo_p1, neg_p1, sf) : 64'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      PREP:    state_nxt = (dvz || !recog) ? DONE : DIV;
      DIV:     if (cnt_p1 == 7'd1) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? PREP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: issue capture; stage p1: iterative quotient/remainder
  always_ff @(posedge clk) begin
    if (accept) begin
      id_p0   <= fu.inst_id;
      inst_p0 <= fu.inst;
      rn_p0   <= fu.op[0];
      rm_p0   <= fu.op[1];
      prn_p0  <= fu.out_prn[0];
    end
    case (state)
      PREP: begin
        rem_p1 <= 64'd0;
        quo_p1 <= dividend;
        dvs_p1 <= rm_mag;
        cnt_p1 <= sf ? 7'd64 : 7'd32;
        neg_p1 <= neg;
      end
      DIV: begin
        rem_p1 <= qbit ? trial[63:0] : rem_sh[63:0];
        quo_p1 <= {quo_p1[62:0], qbit};
        cnt_p1 <= cnt_p1 - 7'd1;
      end
      default: ;
    endcase
  end

  // Completion registers: loaded on the edge that enters DONE, held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q    <= '0;
      prn0_q  <= '0;
      data0_q <= '0;
      slot0_q <= 1'b0;
    end else if (state_nxt == DONE) begin
      id_q    <= id_p0;
      prn0_q  <= prn_p0;
      data0_q <= res_val;
      slot0_q <= recog && !xzr;
    end
  end

  assign fu.busy        = (state == PREP) || (state == DIV) || (state == FIX);
  assign fu.out_valid   = (state == DONE);
  assign fu.out_inst_id = id_q;

  always_comb begin
    fu.out_prn_o         = '0;
    fu.out_data          = '0;
    fu.out_slot_valid    = '0;
    fu.out_prn_o[0]      = prn0_q;
    fu.out_data[0]       = data0_q;
    fu.out_slot_valid[0] = (state == DONE) && slot0_q;
  end

endmodule

// File: tb/tb_div_fu.sv
// Directed bench for div_fu: UDIV/SDIV in X and W forms, divide-by-zero,
// unrecognised encodings, mid-divide reset and back-to-back issue.
module tb_div_fu;
  localparam int IB = 8;
  localparam int PB = 6;
  localparam int MO = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_fu_if #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO)) bus();

  div_fu #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO)) dut (
    .clk (clk),
    .rst (rst),
    .fu  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] id, input logic [31:0] ins, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] prn);
    bus.inst_id    = id;
    bus.inst       = ins;
    bus.op[0]      = a;
    bus.op[1]      = b;
    bus.op[2]      = 64'hA5A5_5A5A_0F0F_F0F0;
    bus.out_prn[0] = prn;
    bus.out_prn[1] = 6'd17;
    bus.out_prn[2] = 6'd33;
    bus.inst_valid = 1'b1;
  endtask

  task automatic issue(input logic [7:0] id, input logic [31:0] ins, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] prn);
    drive(id, ins, a, b, prn);
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
  endtask

  // Returns the edge count from the accept edge to the first edge showing out_valid (0 = timeout)
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_done(input string tag, input logic [7:0] id, input logic [5:0] prn,
                            input logic [63:0] data, input logic sv);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_id"},    64'(bus.out_inst_id), 64'(id));
    check({tag, "_prn"},   64'(bus.out_prn_o[0]), 64'(prn));
    check({tag, "_data"},  bus.out_data[0], data);
    check({tag, "_slots"}, 64'(bus.out_slot_valid), 64'({2'b00, sv}));
    check({tag, "_hidata"}, bus.out_data[1] | bus.out_data[2], 64'd0);
    check({tag, "_hiprn"}, 64'({bus.out_prn_o[2], bus.out_prn_o[1]}), 64'd0);
  endtask

  initial begin
    int lat;
    bit bok;
    int pulses;

    rst            = 1'b0;
    bus.inst_valid = 1'b0;
    bus.inst_id    = '0;
    bus.inst       = '0;
    bus.op         = '0;
    bus.out_prn    = '0;
    bus.pc         = 64'h0000_0000_0040_1000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_id",    64'(bus.out_inst_id), 64'd0);
    check("rst_data",  bus.out_data[0] | bus.out_data[1] | bus.out_data[2], 64'd0);
    check("rst_prn",   64'(bus.out_prn_o), 64'd0);
    check("rst_slots", 64'(bus.out_slot_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // UDIV X3,X1,X2: 100 / 7
    issue(8'h12, 32'h9AC2_0823, 64'd100, 64'd7, 6'd9);
    check("t1_busy0", 64'(bus.busy), 64'd1);
    wait_done(lat, bok);
    check("t1_lat", 64'(lat), 64'd66);
    check("t1_busy", 64'(bok), 64'd1);
    check_done("t1", 8'h12, 6'd9, 64'd14, 1'b1);
    check("t1_busy_done", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("t1_pulse", 64'(bus.out_valid), 64'd0);
    check("t1_slotclr", 64'(bus.out_slot_valid), 64'd0);
    check("t1_hold", bus.out_data[0], 64'd14);

    // SDIV X: -100 / 7 = -14
    issue(8'h21, 32'h9AC2_0C23, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 6'd10);
    wait_done(lat, bok);
    check("t2_lat", 64'(lat), 64'd66);
    check_done("t2", 8'h21, 6'd10, 64'hFFFF_FFFF_FFFF_FFF2, 1'b1);

    // SDIV W: INT_MIN32 / -1 = INT_MIN32, upper operand bits ignored
    issue(8'h22, 32'h1AC2_0C23, 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, 6'd11);
    wait_done(lat, bok);
    check("t3_lat", 64'(lat), 64'd34);
    check_done("t3", 8'h22, 6'd11, 64'h0000_0000_8000_0000, 1'b1);

    // UDIV W: 0xFFFFFFFF / 2 using only the low words
    issue(8'h23, 32'h1AC2_0823, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0002, 6'd12);
    wait_done(lat, bok);
    check("t3b_lat", 64'(lat), 64'd34);
    check_done("t3b", 8'h23, 6'd12, 64'h0000_0000_7FFF_FFFF, 1'b1);

    // SDIV X: INT_MIN64 / -1 = INT_MIN64
    issue(8'h24, 32'h9AC2_0C23, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd13);
    wait_done(lat, bok);
    check("t3c_lat", 64'(lat), 64'd66);
    check_done("t3c", 8'h24, 6'd13, 64'h8000_0000_0000_0000, 1'b1);

    // Divide by zero, with a stray issue pulse while busy
    issue(8'h55, 32'h9AC2_0823, 64'd55, 64'd0, 6'd5);
    check("t4_busy", 64'(bus.busy), 64'd1);
    drive(8'h77, 32'h9AC2_0823, 64'd40, 64'd5, 6'd7);
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
    check_done("t4", 8'h55, 6'd5, 64'd0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    check("t4_nopulse", 64'(pulses), 64'd0);
    check("t4_idle", 64'(bus.busy), 64'd0);

    // Unrecognised encoding completes in one edge with no valid slot
    issue(8'h66, 32'h1234_5678, 64'd10, 64'd2, 6'd4);
    wait_done(lat, bok);
    check("t5_lat", 64'(lat), 64'd1);
    check_done("t5", 8'h66, 6'd4, 64'd0, 1'b0);

    // Reset after 20 divide iterations
    issue(8'h33, 32'h9AC2_0823, 64'd1000, 64'd3, 6'd13);
    repeat (21) @(posedge clk);
    #1;
    check("t6_busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_id", 64'(bus.out_inst_id), 64'd0);
    check("t6_prn", 64'(bus.out_prn_o), 64'd0);
    check("t6_data", bus.out_data[0], 64'd0);
    check("t6_slots", 64'(bus.out_slot_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    check("t6_nopulse", 64'(pulses), 64'd0);
    issue(8'h44, 32'h9AC2_0823, 64'd50, 64'd5, 6'd14);
    wait_done(lat, bok);
    check("t6_lat", 64'(lat), 64'd66);
    check_done("t6", 8'h44, 6'd14, 64'd10, 1'b1);

    // Back-to-back issue in the DONE cycle; second targets XZR
    issue(8'h41, 32'h9AC2_0823, 64'd81, 64'd9, 6'd12);
    wait_done(lat, bok);
    check("t7a_lat", 64'(lat), 64'd66);
    check_done("t7a", 8'h41, 6'd12, 64'd9, 1'b1);
    drive(8'h42, 32'h9AC2_083F, 64'd9, 64'd3, 6'd15);
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
    check("t7b_busy", 64'(bus.busy), 64'd1);
    check("t7b_novalid", 64'(bus.out_valid), 64'd0);
    wait_done(lat, bok);
    check("t7b_lat", 64'(lat), 64'd66);
    check("t7b_busyrun", 64'(bok), 64'd1);
    check_done("t7b", 8'h42, 6'd15, 64'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
